hex_display_ctrl: RTL and testbench

//  Parametrised Avalon-MM 7-segment display controller for the de10lite_qsys system; replaces fixed-width hex PIOs.

---
 rtl/hex_display_pkg.sv | 23 ++
 rtl/hex_display_ctrl_seg7_decode.sv | 15 +
 rtl/hex_display_ctrl.sv | 157 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// hex_display_pkg
//   Shared constants for the 7-segment display controller:
//   register word addresses, CTRL field offsets and the hex-digit
//   segment table (active-high, bit0 = segment a ... bit6 = segment g).
package hex_display_pkg;

  localparam logic [3:0] REG_DATA     = 4'd0;
  localparam logic [3:0] REG_CTRL     = 4'd1;
  localparam logic [3:0] REG_DP       = 4'd2;
  localparam logic [3:0] REG_RAW_BASE = 4'd8;

  localparam int CTRL_DECODE_LSB = 0;
  localparam int CTRL_BLANK_LSB  = 8;
  localparam int CTRL_BLINK_LSB  = 16;
  localparam int CTRL_BRIGHT_LSB = 24;
  localparam int CTRL_ENABLE_BIT = 31;

  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_display_ctrl_seg7_decode.sv
// hex_seg7_decode
//   Combinational nibble to 7-segment decoder (active-high).
//   Ports:
//     i_nibble  in  4  hex digit value
//     o_seg     out 7  segments g..a
module hex_seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_LUT[i_nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Avalon-MM slave driving NUM_DIGITS 7-segment digits with hex decode or
//   raw segment bytes, per-digit blank/blink, decimal points and 16-level
//   PWM brightness. Output is one register stage after the control state.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     address[3:0]          word address
//     chipselect            slave select
//     read_n / write_n      active-low strobes
//     writedata[31:0]       write data
//     readdata[31:0]        registered read data, latency 1, holds otherwise
//     hex_out[8*N-1:0]      digit i at [8i+7:8i], bit7 = dp, bits6..0 = g..a
//   Bus handshake: a write is taken on any cycle with chipselect && !write_n
//   and a read on any cycle with chipselect && !read_n; there is no wait
//   state, readdata is valid the cycle after the read strobe.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int BLINK_DIV      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    read_n,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*8-1:0] hex_out
);

  localparam int ND  = NUM_DIGITS;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  logic [4*ND-1:0] r_data;
  logic [ND-1:0]   r_decode_en;
  logic [ND-1:0]   r_blank;
  logic [ND-1:0]   r_blink;
  logic [ND-1:0]   r_dp;
  logic [3:0]      r_bright;
  logic            r_enable;
  logic [7:0]      r_raw [ND];

  logic [BCW-1:0]  r_blink_cnt;
  logic            r_blink_on;
  logic [3:0]      r_pwm_cnt;

  logic            w_wr;
  logic            w_rd;
  logic            w_pwm_on;
  logic [31:0]     w_rd_val;
  logic [8*ND-1:0] w_next_hex;
  logic            w_unused_wdata;

  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & ~read_n;
  assign w_pwm_on = (r_pwm_cnt <= r_bright);
  // Bits for absent digits and reserved CTRL bits are dropped on write.
  assign w_unused_wdata = ^writedata;

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_decode_en <= '1;
      r_blank     <= '0;
      r_blink     <= '0;
      r_dp        <= '0;
      r_bright    <= 4'hF;
      r_enable    <= 1'b0;
      for (int i = 0; i < ND; i++) r_raw[i] <= 8'h00;
    end else if (w_wr) begin
      case (address)
        REG_DATA: r_data <= writedata[4*ND-1:0];
        REG_CTRL: begin
          r_decode_en <= writedata[CTRL_DECODE_LSB +: ND];
          r_blank     <= writedata[CTRL_BLANK_LSB  +: ND];
          r_blink     <= writedata[CTRL_BLINK_LSB  +: ND];
          r_bright    <= writedata[CTRL_BRIGHT_LSB +: 4];
          r_enable    <= writedata[CTRL_ENABLE_BIT];
        end
        REG_DP: r_dp <= writedata[ND-1:0];
        default: begin
          for (int i = 0; i < ND; i++)
            if (address == REG_RAW_BASE + 4'(i)) r_raw[i] <= writedata[7:0];
        end
      endcase
    end
  end

  // Read mux; sampled before any same-cycle write lands.
  always_comb begin
    w_rd_val = '0;
    case (address)
      REG_DATA: w_rd_val[4*ND-1:0] = r_data;
      REG_CTRL: begin
        w_rd_val[CTRL_DECODE_LSB +: ND] = r_decode_en;
        w_rd_val[CTRL_BLANK_LSB  +: ND] = r_blank;
        w_rd_val[CTRL_BLINK_LSB  +: ND] = r_blink;
        w_rd_val[CTRL_BRIGHT_LSB +: 4]  = r_bright;
        w_rd_val[CTRL_ENABLE_BIT]       = r_enable;
      end
      REG_DP: w_rd_val[ND-1:0] = r_dp;
      default: begin
        for (int i = 0; i < ND; i++)
          if (address == REG_RAW_BASE + 4'(i)) w_rd_val[7:0] = r_raw[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     readdata <= '0;
    else if (w_rd) readdata <= w_rd_val;
  end

  // Free-running blink and PWM timebases; no bus access touches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_pwm_cnt   <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_digit
    logic [6:0] w_lut;
    logic [7:0] w_seg;
    logic       w_lit;

    hex_seg7_decode u_dec (
      .i_nibble (r_data[4*g +: 4]),
      .o_seg    (w_lut)
    );

    assign w_seg = r_decode_en[g] ? {r_dp[g], w_lut} : r_raw[g];
    assign w_lit = r_enable & ~r_blank[g] & (~r_blink[g] | r_blink_on) & w_pwm_on;
    assign w_next_hex[8*g +: 8] = w_lit ? w_seg : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) hex_out <= {(8*ND){INV}};
    else       hex_out <= w_next_hex ^ {(8*ND){INV}};
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl
//   Directed + random bench for hex_display_ctrl (6 digits, BLINK_DIV=8,
//   active-low segments). A reference model at the falling edge predicts
//   hex_out and readdata after the next rising edge; a monitor compares.
module tb_hex_display_ctrl;

  localparam int ND   = 6;
  localparam int BDIV = 8;
  localparam int W    = 8 * ND;
  localparam logic [31:0] DMASK = (ND == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4*ND)) - 32'd1);
  localparam logic [31:0] BMASK = (32'd1 << ND) - 32'd1;
  localparam logic [31:0] CMASK = 32'h8F00_0000 | BMASK | (BMASK << 8) | (BMASK << 16);

  logic          clk;
  logic          reset;
  logic [3:0]    address;
  logic          chipselect;
  logic          read_n;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  hex_out;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BDIV), .SEG_ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model state (register contents as read back)
  logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0] m_data, m_ctrl, m_dp;
  logic [7:0]  m_raw [ND];
  int unsigned m_j;      // rising edges since the last reset edge
  bit          m_valid = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  rd_q[$];
  bit           rdf_q[$];

  function automatic logic [31:0] ref_read(input logic [3:0] a);
    if (a == 4'd0) return m_data;
    if (a == 4'd1) return m_ctrl;
    if (a == 4'd2) return m_dp;
    if (a >= 4'd8 && int'(a) < 8 + ND) return {24'h0, m_raw[a - 4'd8]};
    return 32'h0;
  endfunction

  function automatic logic [W-1:0] ref_hex();
    logic [W-1:0] h;
    logic [7:0]   seg;
    bit           blink_on, lit;
    int           pwm;
    blink_on = ((m_j / BDIV) % 2) == 0;
    pwm      = m_j % 16;
    for (int i = 0; i < ND; i++) begin
      seg = m_ctrl[i] ? {m_dp[i], lut[m_data[4*i +: 4]]} : m_raw[i];
      lit = m_ctrl[31] && !m_ctrl[8+i] && (!m_ctrl[16+i] || blink_on)
            && (pwm <= int'(m_ctrl[27:24]));
      h[8*i +: 8] = ~(lit ? seg : 8'h00);
    end
    return h;
  endfunction

  // model: inputs are stable at the falling edge; predict next-edge outputs
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_q.push_back({W{1'b1}});
      rdf_q.push_back(1'b1);
      rd_q.push_back(32'h0);
      m_data = 0; m_ctrl = 32'h0F00_0000 | BMASK; m_dp = 0;
      for (int i = 0; i < ND; i++) m_raw[i] = 8'h00;
      m_j = 0;
      m_valid = 1;
    end else if (m_valid) begin
      exp_q.push_back(ref_hex());
      if (chipselect && !read_n) begin
        rdf_q.push_back(1'b1);
        rd_q.push_back(ref_read(address));
      end else begin
        rdf_q.push_back(1'b0);
      end
      if (chipselect && !write_n) begin
        if (address == 4'd0) m_data = writedata & DMASK;
        else if (address == 4'd1) m_ctrl = writedata & CMASK;
        else if (address == 4'd2) m_dp = writedata & BMASK;
        else if (address >= 4'd8 && int'(address) < 8 + ND) m_raw[address - 4'd8] = writedata[7:0];
      end
      m_j++;
    end
  end

  // monitor
  always @(posedge clk) begin
    logic [W-1:0] eh;
    logic [31:0]  er;
    bit           f;
    #2;
    if (exp_q.size() > 0) begin
      eh = exp_q.pop_front();
      check("hex_out", 64'(hex_out), 64'(eh));
    end
    if (rdf_q.size() > 0) begin
      f = rdf_q.pop_front();
      if (f && rd_q.size() > 0) begin
        er = rd_q.pop_front();
        check("readdata", 64'(readdata), 64'(er));
      end
    end
  end

  // drivers
  task automatic drive(input bit rst, input bit cs, input bit rd, input bit wr,
                       input logic [3:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = rst; chipselect = cs; read_n = ~rd; write_n = ~wr;
    address = a; writedata = d;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    drive(0, 1, 0, 1, a, d);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    drive(0, 1, 1, 0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      idle(1);
      if (hex_out[0] == 1'b0) cnt++;
    end
  endtask

  int lows;

  initial begin
    reset = 1; chipselect = 0; read_n = 1; write_n = 1; address = 0; writedata = 0;
    repeat (3) drive(1, 0, 0, 0, 4'h0, 32'h0);
    idle(1);
    check("reset_hex", 64'(hex_out), 64'({W{1'b1}}));
    check("reset_readdata", 64'(readdata), 64'h0);
    rd_reg(4'd1); rd_reg(4'd0); idle(2);

    // decode
    wr_reg(4'd0, 32'h0012_3456);
    wr_reg(4'd1, 32'h8F00_003F);
    idle(2);
    check("digit0_six", 64'(hex_out[7:0]), 64'h82);
    check("digit5_one", 64'(hex_out[47:40]), 64'hF9);

    // brightness
    wr_reg(4'd1, 32'h8300_003F); idle(4);
    count_low(lows); check("bright3_low", 64'(lows), 64'd4);
    wr_reg(4'd1, 32'h8000_003F); idle(4);
    count_low(lows); check("bright0_low", 64'(lows), 64'd1);

    // raw segments and decimal point
    wr_reg(4'd1, 32'h8F00_003E);
    wr_reg(4'd8, 32'h0000_0049);
    idle(2);
    check("raw0", 64'(hex_out[7:0]), 64'hB6);
    wr_reg(4'd1, 32'h8F00_003F);
    wr_reg(4'd2, 32'h0000_0001);
    idle(2);
    check("dp0", 64'(hex_out[7:0]), 64'h02);

    // blink, with a mid-period CTRL rewrite
    wr_reg(4'd1, 32'h8F02_003F); idle(21);
    wr_reg(4'd1, 32'h8F02_003F); idle(30);

    // unmapped address, masked DATA, same-cycle read/write
    wr_reg(4'd5, 32'hFFFF_FFFF);
    wr_reg(4'd0, 32'hFFFF_FFFF);
    rd_reg(4'd5); rd_reg(4'd0);
    drive(0, 1, 1, 1, 4'd0, 32'h1234_5678);
    rd_reg(4'd0); idle(2);

    // reset mid-blink
    wr_reg(4'd1, 32'h8F3F_003F); idle(5);
    drive(1, 1, 0, 1, 4'd1, 32'h8F00_0000);
    idle(1);
    check("midreset_hex", 64'(hex_out), 64'({W{1'b1}}));
    rd_reg(4'd1); idle(2);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      int op;
      logic [3:0]  a;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (a == 4'd1) d[31] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) drive(1, 0, 0, 0, 4'h0, 32'h0);
      else if (op <= 2) wr_reg(a, d);
      else if (op <= 4) rd_reg(a);
      else if (op == 5) drive(0, 1, 1, 1, a, d);
      else idle(1);
    end

    idle(3);
    #2;
    check("queues_drained", 64'(exp_q.size() + rd_q.size() + rdf_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
